// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle control unit
package ctrl_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_BEQ = 4'b0111;
  localparam logic [3:0] ALU_ORI = 4'b0001;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b1011;
  localparam logic [3:0] ALU_SLT = 4'b1001;
  localparam logic [1:0] JMP_NONE = 2'd0;
  localparam logic [1:0] JMP_TGT  = 2'd1;
  localparam logic [1:0] JMP_RS   = 2'd2;
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;
  localparam logic [1:0] SRCB_RT  = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {C_R, C_IARITH, C_LOAD, C_STORE, C_BEQ, C_J, C_JAL, C_JR} iclass_t;
endpackage

// File: rtl/instr_class_dec.sv
// instr_class_dec: maps latched op/funct to instruction class, ALU code, extension and legality
module instr_class_dec import ctrl_pkg::*; #(
  parameter bit HAS_BYTE = 1
) (
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_t    iclass_o,
  output logic [3:0] alu_code_o,
  output logic       ext_op_o,
  output logic       illegal_o
);
  // decode table; byte accesses become illegal when the datapath lacks byte lanes
  always_comb begin
    iclass_o = C_R;
    alu_code_o = ALU_ADD;
    ext_op_o = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_R:
        case (funct_i)
          FN_ADD:          alu_code_o = ALU_ADD;
          FN_SUB:          alu_code_o = ALU_SUB;
          FN_SLL, FN_SLLV: alu_code_o = ALU_SLL;
          FN_SLT:          alu_code_o = ALU_SLT;
          FN_JR:           iclass_o = C_JR;
          default:         illegal_o = 1'b1;
        endcase
      OP_BEQ:  begin iclass_o = C_BEQ; alu_code_o = ALU_BEQ; ext_op_o = 1'b1; end
      OP_ORI:  begin iclass_o = C_IARITH; alu_code_o = ALU_ORI; end
      OP_LUI:  begin iclass_o = C_IARITH; alu_code_o = ALU_LUI; end
      OP_ADDI: begin iclass_o = C_IARITH; ext_op_o = 1'b1; end
      OP_LW:   begin iclass_o = C_LOAD; ext_op_o = 1'b1; end
      OP_SW:   begin iclass_o = C_STORE; ext_op_o = 1'b1; end
      OP_LB:   begin iclass_o = C_LOAD; ext_op_o = 1'b1; illegal_o = !HAS_BYTE; end
      OP_SB:   begin iclass_o = C_STORE; ext_op_o = 1'b1; illegal_o = !HAS_BYTE; end
      OP_J:    iclass_o = C_J;
      OP_JAL:  iclass_o = C_JAL;
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving Moore datapath controls
module multicycle_ctrl import ctrl_pkg::*; #(
  parameter int ALUCTR_W = 4,
  parameter int CNT_W    = 32,
  parameter bit HAS_BYTE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_byte,
  output logic                pc_write,
  output logic                ir_write,
  output logic                branch,
  output logic [1:0]          jump,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_op,
  output logic                sll_en,
  output logic [ALUCTR_W-1:0] alu_ctr,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);
  state_t            state_q, state_d;
  logic [5:0]        op_q, funct_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  retired_q;
  logic              retire;
  iclass_t           cls;
  logic [3:0]        alu_code;
  logic              dec_ext, dec_ill;
  logic              is_jmp, is_mem, is_store, is_sll, is_byte;
  instr_class_dec #(.HAS_BYTE(HAS_BYTE)) u_dec (
    .op_i(op_q), .funct_i(funct_q), .iclass_o(cls),
    .alu_code_o(alu_code), .ext_op_o(dec_ext), .illegal_o(dec_ill)
  );
  assign is_jmp   = cls inside {C_J, C_JAL, C_JR};
  assign is_store = cls == C_STORE;
  assign is_mem   = is_store || cls == C_LOAD;
  assign is_sll   = cls == C_R && op_q == OP_R && funct_q == FN_SLL;
  assign is_byte  = op_q == OP_SB || op_q == OP_LB;
  assign illegal  = illegal_q || (state_q == S_DECODE && dec_ill);
  assign retired  = retired_q;
  // next state and per-state controls; only FETCH's IR/PC writes look at mem_ack
  always_comb begin
    state_d = state_q;
    retire = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_byte = 1'b0;
    pc_write = 1'b0;
    ir_write = 1'b0;
    branch = 1'b0;
    jump = JMP_NONE;
    reg_write = 1'b0;
    reg_dst = RD_RT;
    mem_to_reg = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RT;
    ext_op = 1'b0;
    sll_en = 1'b0;
    alu_ctr = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        alu_src_b = SRCB_4;
        alu_ctr = ALUCTR_W'(ALU_ADD);
        ir_write = mem_ack;
        pc_write = mem_ack;
        state_d = mem_ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_d = dec_ill ? S_FETCH : S_EXEC;
      S_EXEC: begin
        alu_src_a = !is_jmp;
        alu_src_b = (cls == C_R || cls == C_BEQ || is_jmp) ? SRCB_RT : SRCB_IMM;
        ext_op = dec_ext;
        alu_ctr = is_jmp ? '0 : ALUCTR_W'(alu_code);
        branch = cls == C_BEQ;
        jump = (cls == C_J || cls == C_JAL) ? JMP_TGT : cls == C_JR ? JMP_RS : JMP_NONE;
        reg_write = cls == C_JAL;
        reg_dst = cls == C_JAL ? RD_RA : RD_RT;
        sll_en = is_sll;
        retire = is_jmp || cls == C_BEQ;
        state_d = retire ? S_FETCH : is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we = is_store;
        mem_byte = is_byte;
        retire = is_store && mem_ack;
        state_d = !mem_ack ? S_MEM : is_store ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst = cls == C_R ? RD_RD : RD_RT;
        mem_to_reg = cls == C_LOAD;
        sll_en = is_sll;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state, latched instruction fields, sticky illegal flag and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q <= '0;
      funct_q <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_write) begin
        op_q <= op;
        funct_q <= funct;
      end
      if (state_q == S_DECODE && dec_ill) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle successor to the single-cycle control decoder of the P4 CPU. It holds a state machine that steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives per-state datapath controls. It waits on a memory handshake in FETCH and MEM, flags illegal encodings, and counts retired instructions. It sits between the instruction/data memory port and the shared multi-cycle datapath (PC, IR, regfile, ALU).

## Interface
- `ALUCTR_W`, default 4: ALU control width. Codes are zero-extended from the 4-bit set.
- `CNT_W`, default 32: retired-instruction counter width.
- `HAS_BYTE`, default 1: when 0, sb/lb decode as illegal.
- `clk  in  1`: the single clock.
- `reset  in  1`: asynchronous, active-low reset.
- `op  in  6`: instruction[31:26]. Sampled only on the FETCH cycle where `mem_ack`=1.
- `funct  in  6`: instruction[5:0]. Sampled with `op`.
- `mem_ack  in  1`: memory completes the current request this cycle.
- `mem_req  out  1`: memory access request, held until `mem_ack`.
- `mem_we  out  1`: request is a write.
- `mem_byte  out  1`: request is a byte access (sb/lb).
- `pc_write  out  1`: PC <= PC+4.
- `ir_write  out  1`: IR load.
- `branch  out  1`: PC <= branch target if ALU zero.
- `jump  out  2`: PC source. 0 none, 1 j/jal target, 2 rs (jr).
- `reg_write  out  1`: regfile write enable.
- `reg_dst  out  2`: 0 rt, 1 rd, 2 $31.
- `mem_to_reg  out  1`: write-back from memory data.
- `alu_src_a  out  1`: 0 PC, 1 rs/shamt path.
- `alu_src_b  out  2`: 0 rt, 1 const 4, 2 imm.
- `ext_op  out  1`: sign-extend the immediate.
- `sll_en  out  1`: ALU A takes shamt.
- `alu_ctr  out  ALUCTR_W`: ALU operation.
- `illegal  out  1`: sticky flag for an unsupported encoding.
- `retired  out  CNT_W`: count of completed instructions.

## Operation
- Decode set:
  - R-type (op 000000): add 100000, sub 100010, sll 000000, sllv 000100, slt 101010, jr 001000.
  - Other ops: beq 000100, ori 001101, lui 001111, lw 100011, sw 101011, addi 001000, j 000010, jal 000011, sb 101000, lb 100000.
- `op` and `funct` are latched internally at FETCH completion. All later states decode from the latched copy.
- ALU codes: add 0010, sub 0110, beq 0111, ori 0001, lui 0101, sll/sllv 1011, slt 1001.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: entered on reset. All outputs 0. Moves unconditionally to FETCH on the next clk.
- FETCH: `mem_req`=1, `alu_src_a`=0, `alu_src_b`=1, `alu_ctr`=0010. Stays in FETCH while `mem_ack`=0. When `mem_ack`=1: `ir_write`=1, `pc_write`=1, go to DECODE.
- DECODE: no writes.
  - Illegal encoding: set `illegal`, go to FETCH. The instruction is not counted.
  - j/jal/jr: go to EXEC (jump class).
  - All others: go to EXEC.
- EXEC, by class:
  - R and I-arith: drive `alu_ctr`, `alu_src_b` (2 for ori/lui/addi), `ext_op` (addi). Go to WB.
  - lw/lb/sw/sb: `alu_src_b`=2, `ext_op`=1, `alu_ctr`=0010. Go to MEM.
  - beq: `alu_ctr`=0111, `branch`=1, `ext_op`=1. Retire, go to FETCH.
  - j: `jump`=1. jal: `jump`=1, `reg_write`=1, `reg_dst`=2. jr: `jump`=2. All retire, go to FETCH.
- MEM: `mem_req`=1; `mem_we`=1 for sw/sb; `mem_byte` for sb/lb. Stays in MEM while `mem_ack`=0.
  - Stores: retire on ack, go to FETCH.
  - Loads: go to WB on ack.
- WB: `reg_write`=1.
  - `reg_dst`=1 for R-type, else 0.
  - `mem_to_reg`=1 for lw/lb.
  - `sll_en` is held from EXEC through WB for sll.
  - Retire, go to FETCH.
- Retire: `retired` <= `retired`+1 and wraps modulo 2^CNT_W.
- `illegal` is sticky until reset. It never stalls the FSM.

## Timing
- Control outputs are Moore: a function of the state register and the latched op/funct only. `op`, `funct` and `mem_ack` never combinationally affect controls other than FETCH's `ir_write`/`pc_write`.
- Cycles with zero-wait memory:
  - beq, j, jal, jr: 3.
  - R-type, I-arith, sw, sb: 4.
  - lw, lb: 5.
- Each memory wait cycle adds 1.
- `mem_req` stays asserted with stable `mem_we`/`mem_byte` until `mem_ack`.
- Async reset mid-instruction: state goes to IDLE, `retired`=0, `illegal`=0, latched op/funct=0, all outputs 0 immediately. A pending memory request is abandoned.

## Structure
- Shared package `ctrl_pkg` holds:
  - opcode/funct localparams;
  - ALU code constants;
  - the state enum;
  - `jump`/`reg_dst`/`alu_src_b` encodings.
- One sub-module, `instr_class_dec`, is combinational. It maps latched op/funct to class, `alu_ctr`, `ext_op` and `illegal`, and is gated by `HAS_BYTE`.

## Test plan
- Reset held, then released with `mem_ack`=1 constant → IDLE, then FETCH with `mem_req`=1. add completes in 4 cycles. `retired`=1, WB has `reg_write`=1, `reg_dst`=1.
- lw with `mem_ack` low for 2 cycles in FETCH and 3 in MEM → 10 cycles total. `mem_req` is stable throughout and `mem_to_reg`=1 in WB.
- jal → EXEC asserts `jump`=1, `reg_write`=1, `reg_dst`=2. 3 cycles total.
- op=111111 → `illegal`=1 from the DECODE cycle onward, `retired` unchanged, next state FETCH.
- `HAS_BYTE`=0 with sb → `illegal`=1, `mem_req` never asserted for MEM.
- `CNT_W`=4, 17 beq instructions → `retired` wraps to 1. Reset asserted mid-MEM of sw → all outputs 0 in the same cycle, `retired`=0.
